// File: rtl/onehot_demux_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : onehot_demux_if
// Description : Stream bundle for the one-hot demultiplexer. One input
//               valid/ready stream carrying a one-hot destination select and
//               OUTPUTS independent valid/ready output channels.
//   in_data   : input beat payload
//   in_sel    : one-hot destination; bit OUTPUTS-1-i selects channel i
//   in_valid  : input beat valid
//   in_ready  : input beat accepted when in_valid && in_ready
//   out_data  : per-channel payload (unpacked, index = channel)
//   out_valid : per-channel valid
//   out_ready : per-channel ready
//   Modports  : master = producer/consumer side, slave = demux side
// Revision    : 1.0 - initial release
// ============================================================================
interface onehot_demux_if #(
    parameter int OUTPUTS = 4,
    parameter int WIDTH   = 8
);
    logic [WIDTH-1:0]   in_data;
    logic [OUTPUTS-1:0] in_sel;
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   out_data [OUTPUTS];
    logic [OUTPUTS-1:0] out_valid;
    logic [OUTPUTS-1:0] out_ready;

    modport master (
        output in_data,
        output in_sel,
        output in_valid,
        input  in_ready,
        input  out_data,
        input  out_valid,
        output out_ready
    );

    modport slave (
        input  in_data,
        input  in_sel,
        input  in_valid,
        output in_ready,
        output out_data,
        output out_valid,
        input  out_ready
    );
endinterface
`default_nettype wire

// File: rtl/onehot_demux.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : onehot_demux
// Description : Registered one-hot demultiplexer. Steers one valid/ready
//               input stream to one of OUTPUTS output channels chosen by a
//               one-hot select travelling with each beat. Every channel owns
//               a one-entry holding register, so a stalled channel only
//               blocks beats addressed to it. Beats with an illegal select
//               (zero or several bits set) are consumed and counted.
// Ports       :
//   clk       : clock, rising edge
//   rst_n     : asynchronous active-low reset
//   bus       : onehot_demux_if.slave stream bundle
//   err_pulse : one-cycle pulse after an illegal beat was consumed
//   err_count : saturating count of illegal beats
// Revision    : 1.0 - initial release
// ============================================================================
module onehot_demux #(
    parameter int OUTPUTS   = 4,
    parameter int WIDTH     = 8,
    parameter int CNT_WIDTH = 8
) (
    input  wire logic                 clk,
    input  wire logic                 rst_n,
    onehot_demux_if.slave             bus,
    output logic                      err_pulse,
    output logic [CNT_WIDTH-1:0]      err_count
);

    localparam logic [OUTPUTS-1:0]   c_sel_one = OUTPUTS'(1);
    localparam logic [CNT_WIDTH-1:0] c_cnt_one = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] c_cnt_max = {CNT_WIDTH{1'b1}};

    logic [OUTPUTS-1:0]   w_dest;     // select re-indexed by channel number
    logic [OUTPUTS-1:0]   w_valid;
    logic [OUTPUTS-1:0]   w_load;
    logic                 w_sel_ok;
    logic                 w_accept;
    logic                 w_illegal;
    logic                 r_err_pulse;
    logic [CNT_WIDTH-1:0] r_err_count;

    // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
    assign w_sel_ok = (bus.in_sel != '0) &&
                      ((bus.in_sel & (bus.in_sel - c_sel_one)) == '0);

    // MSB of the select addresses channel 0, matching the one-hot mux.
    generate
        for (genvar i = 0; i < OUTPUTS; i++) begin : g_dest
            assign w_dest[i] = bus.in_sel[OUTPUTS-1-i];
        end
    endgenerate

    // With a legal select only one w_dest bit is set, so the reduction picks
    // the addressed channel: it can take a beat when empty or draining now.
    // Illegal selects are always accepted so they never stall the producer.
    assign bus.in_ready = !w_sel_ok || (|(w_dest & (~w_valid | bus.out_ready)));
    assign w_accept     = bus.in_valid && bus.in_ready && w_sel_ok;
    assign w_illegal    = bus.in_valid && !w_sel_ok;
    assign w_load       = w_accept ? w_dest : '0;

    generate
        for (genvar i = 0; i < OUTPUTS; i++) begin : g_chan
            logic             r_valid;
            logic [WIDTH-1:0] r_data;

            // A load wins over a drain, which gives full throughput when the
            // consumer takes the held beat on the same edge a new one arrives.
            // Data is only written on a load, so a stalled beat stays stable.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_valid <= 1'b0;
                    r_data  <= '0;
                end else if (w_load[i]) begin
                    r_valid <= 1'b1;
                    r_data  <= bus.in_data;
                end else if (bus.out_ready[i]) begin
                    r_valid <= 1'b0;
                end
            end

            assign w_valid[i]      = r_valid;
            assign bus.out_data[i] = r_data;
        end
    endgenerate

    assign bus.out_valid = w_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_pulse <= 1'b0;
            r_err_count <= '0;
        end else begin
            r_err_pulse <= w_illegal;
            if (w_illegal && (r_err_count != c_cnt_max)) begin
                r_err_count <= r_err_count + c_cnt_one;
            end
        end
    end

    assign err_pulse = r_err_pulse;
    assign err_count = r_err_count;

endmodule
`default_nettype wire

// File: tb/tb_onehot_demux.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_onehot_demux
// Description : Self-checking bench for onehot_demux (4 channels, 8-bit data,
//               8-bit error counter). Hand-written vector table, directed
//               backpressure / reset / saturation sequences and randomized
//               traffic scored against a behavioural model with per-channel
//               expected-beat queues.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_onehot_demux;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          err_pulse;
    logic [CW-1:0] err_count;

    always #5 clk = ~clk;

    onehot_demux_if #(.OUTPUTS(N), .WIDTH(W)) bus ();

    onehot_demux #(.OUTPUTS(N), .WIDTH(W), .CNT_WIDTH(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .err_pulse (err_pulse),
        .err_count (err_count)
    );

    int checks = 0;
    int errors = 0;

    // Behavioural model: per-channel held beat plus error bookkeeping.
    logic         m_valid [N];
    logic [W-1:0] m_data  [N];
    logic         m_pulse;
    int           m_cnt;
    logic [W-1:0] sbq [N][$];      // beats accepted but not yet delivered
    logic         prev_stall;
    logic [N-1:0] prev_sel;
    logic [W-1:0] prev_data;
    logic         last_ready;
    logic         last_exp_ready;

    typedef struct {
        logic         v;
        logic [N-1:0] sel;
        logic [W-1:0] data;
        logic [N-1:0] rdy;
        logic         exp_ready;
        logic [N-1:0] exp_valid;
        int           ch;
        logic [W-1:0] exp_d;
        logic         exp_pulse;
        int           exp_cnt;
    } vec_t;

    vec_t tbl [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [N-1:0] model_valid_vec();
        logic [N-1:0] mv;
        for (int i = 0; i < N; i++) mv[i] = m_valid[i];
        return mv;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_valid[i] = 1'b0;
            m_data[i]  = '0;
            sbq[i].delete();
        end
        m_pulse    = 1'b0;
        m_cnt      = 0;
        prev_stall = 1'b0;
    endtask

    // One clock of stimulus with model scoring before and after the edge.
    task automatic cycle(input logic v, input logic [N-1:0] sel,
                         input logic [W-1:0] data, input logic [N-1:0] rdy);
        logic legal;
        int   dest;
        logic exp_rdy;
        logic accept;
        @(negedge clk);
        bus.in_valid  = v;
        bus.in_sel    = sel;
        bus.in_data   = data;
        bus.out_ready = rdy;
        #1;
        legal = ($countones(sel) == 1);
        dest  = 0;
        for (int i = 0; i < N; i++) if (sel[N-1-i]) dest = i;
        exp_rdy = legal ? (!m_valid[dest] || rdy[dest]) : 1'b1;
        last_ready     = bus.in_ready;
        last_exp_ready = exp_rdy;
        chk("in_ready", {31'd0, bus.in_ready}, {31'd0, exp_rdy});
        if (prev_stall)
            chk("protocol_hold", {23'd0, v, sel, data}, {23'd0, 1'b1, prev_sel, prev_data});
        // Deliveries this cycle must match the oldest accepted beat.
        for (int i = 0; i < N; i++) begin
            if (m_valid[i] && rdy[i]) begin
                checks++;
                if (sbq[i].size() == 0) begin
                    errors++;
                    $display("FAIL stream_ch%0d actual=delivery required=no_beat_pending", i);
                end else begin
                    logic [W-1:0] e;
                    e = sbq[i].pop_front();
                    if (bus.out_data[i] !== e) begin
                        errors++;
                        $display("FAIL stream_ch%0d actual=%0h required=%0h", i, bus.out_data[i], e);
                    end
                end
            end
        end
        accept = v && exp_rdy && legal;
        if (accept) sbq[dest].push_back(data);
        prev_stall = v && !exp_rdy;
        prev_sel   = sel;
        prev_data  = data;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (accept && dest == i) begin
                m_valid[i] = 1'b1;
                m_data[i]  = data;
            end else if (m_valid[i] && rdy[i]) begin
                m_valid[i] = 1'b0;
            end
        end
        m_pulse = v && !legal;
        if (m_pulse && m_cnt < (1 << CW) - 1) m_cnt++;
        chk("out_valid", {28'd0, bus.out_valid}, {28'd0, model_valid_vec()});
        for (int i = 0; i < N; i++)
            chk($sformatf("out_data%0d", i), {24'd0, bus.out_data[i]}, {24'd0, m_data[i]});
        chk("err_pulse", {31'd0, err_pulse}, {31'd0, m_pulse});
        chk("err_count", {24'd0, err_count}, m_cnt);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N-1:0] legal_sel [4];
        logic [N-1:0] bad_sel   [4];
        logic [N-1:0] sel;
        logic [W-1:0] cur_data;
        logic         v;
        int           idx;
        int           cyc;

        legal_sel = '{4'b1000, 4'b0100, 4'b0010, 4'b0001};
        bad_sel   = '{4'b0000, 4'b0110, 4'b1111, 4'b1001};

        // Directed table: routing then illegal selects, from reset state.
        tbl[0] = '{1'b1, 4'b1000, 8'hA5, 4'b1111, 1'b1, 4'b0001, 0, 8'hA5, 1'b0, 0};
        tbl[1] = '{1'b1, 4'b0001, 8'h3C, 4'b1111, 1'b1, 4'b1000, 3, 8'h3C, 1'b0, 0};
        tbl[2] = '{1'b0, 4'b0000, 8'h00, 4'b1111, 1'b1, 4'b0000, 3, 8'h3C, 1'b0, 0};
        tbl[3] = '{1'b1, 4'b0110, 8'hFF, 4'b1111, 1'b1, 4'b0000, 0, 8'hA5, 1'b1, 1};
        tbl[4] = '{1'b1, 4'b0000, 8'hEE, 4'b1111, 1'b1, 4'b0000, 3, 8'h3C, 1'b1, 2};
        tbl[5] = '{1'b0, 4'b0110, 8'h00, 4'b1111, 1'b1, 4'b0000, 2, 8'h00, 1'b0, 2};

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_sel    = '0;
        bus.in_data   = '0;
        bus.out_ready = '0;
        model_reset();
        #1;
        chk("reset_out_valid", {28'd0, bus.out_valid}, 32'd0);
        chk("reset_err_count", {24'd0, err_count}, 32'd0);
        chk("reset_err_pulse", {31'd0, err_pulse}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic routing and illegal selects.
        for (int k = 0; k < 6; k++) begin
            cycle(tbl[k].v, tbl[k].sel, tbl[k].data, tbl[k].rdy);
            chk($sformatf("tbl%0d_in_ready", k), {31'd0, last_ready}, {31'd0, tbl[k].exp_ready});
            chk($sformatf("tbl%0d_out_valid", k), {28'd0, bus.out_valid}, {28'd0, tbl[k].exp_valid});
            chk($sformatf("tbl%0d_out_data", k), {24'd0, bus.out_data[tbl[k].ch]}, {24'd0, tbl[k].exp_d});
            chk($sformatf("tbl%0d_err_pulse", k), {31'd0, err_pulse}, {31'd0, tbl[k].exp_pulse});
            chk($sformatf("tbl%0d_err_count", k), {24'd0, err_count}, tbl[k].exp_cnt);
        end

        // Backpressure on channel 2 while channel 1 keeps flowing.
        cycle(1'b1, 4'b0010, 8'h11, 4'b1011);
        chk("bp_first_ready", {31'd0, last_ready}, 32'd1);
        chk("bp_ch2_held", {24'd0, bus.out_data[2]}, 32'h11);
        cycle(1'b1, 4'b0100, 8'h77, 4'b1011);
        chk("bp_other_valid", {28'd0, bus.out_valid}, 32'b0110);
        chk("bp_ch1_data", {24'd0, bus.out_data[1]}, 32'h77);
        cycle(1'b1, 4'b0010, 8'h22, 4'b1011);
        chk("bp_stall_ready", {31'd0, last_ready}, 32'd0);
        chk("bp_hold_data", {24'd0, bus.out_data[2]}, 32'h11);
        cycle(1'b1, 4'b0010, 8'h22, 4'b1011);
        chk("bp_stall_ready2", {31'd0, last_ready}, 32'd0);
        cycle(1'b1, 4'b0010, 8'h22, 4'b1111);
        chk("bp_release_ready", {31'd0, last_ready}, 32'd1);
        chk("bp_release_valid", {28'd0, bus.out_valid}, 32'b0100);
        chk("bp_release_data", {24'd0, bus.out_data[2]}, 32'h22);
        cycle(1'b0, 4'b0000, 8'h00, 4'b1111);
        chk("bp_drained", {28'd0, bus.out_valid}, 32'd0);

        // Counter saturation with back-to-back illegal beats.
        for (int k = 0; k < 260; k++)
            cycle(1'b1, bad_sel[$urandom_range(0, 3)], W'($urandom), N'($urandom));
        chk("sat_count", {24'd0, err_count}, 32'd255);
        chk("sat_pulse", {31'd0, err_pulse}, 32'd1);
        cycle(1'b0, 4'b0000, 8'h00, 4'b1111);
        chk("sat_hold", {24'd0, err_count}, 32'd255);

        // Asynchronous reset mid-run with two channels holding beats.
        cycle(1'b1, 4'b1000, 8'hAA, 4'b0000);
        cycle(1'b1, 4'b0010, 8'hBB, 4'b0000);
        chk("pre_reset_valid", {28'd0, bus.out_valid}, 32'b0101);
        @(negedge clk);
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        chk("async_out_valid", {28'd0, bus.out_valid}, 32'd0);
        for (int i = 0; i < N; i++)
            chk($sformatf("async_out_data%0d", i), {24'd0, bus.out_data[i]}, 32'd0);
        chk("async_err_count", {24'd0, err_count}, 32'd0);
        chk("async_err_pulse", {31'd0, err_pulse}, 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        chk("reset_hold_valid", {28'd0, bus.out_valid}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cycle(1'b1, 4'b0100, 8'h5A, 4'b1111);
        chk("post_reset_valid", {28'd0, bus.out_valid}, 32'b0010);
        chk("post_reset_data", {24'd0, bus.out_data[1]}, 32'h5A);

        // Full-rate round-robin streaming with random consumer readiness.
        idx      = 0;
        cyc      = 0;
        cur_data = W'($urandom);
        while (idx < 64 && cyc < 2000) begin
            cycle(1'b1, legal_sel[idx % 4], cur_data, N'($urandom));
            if (last_exp_ready) begin
                idx++;
                cur_data = W'($urandom);
            end
            cyc++;
        end
        chk("stream_sent", idx, 32'd64);

        // Mixed random traffic, legal and illegal, honouring the hold rule.
        sel      = legal_sel[0];
        cur_data = '0;
        v        = 1'b0;
        for (int k = 0; k < 200; k++) begin
            if (!prev_stall) begin
                v        = ($urandom_range(0, 3) != 0);
                sel      = ($urandom_range(0, 4) == 0) ? bad_sel[$urandom_range(0, 3)]
                                                       : legal_sel[$urandom_range(0, 3)];
                cur_data = W'($urandom);
            end
            cycle(v, sel, cur_data, N'($urandom));
        end

        // Drain everything still held and confirm nothing was lost.
        cyc = 0;
        while (cyc < 20) begin
            cycle(1'b0, 4'b0000, 8'h00, 4'b1111);
            cyc++;
        end
        for (int i = 0; i < N; i++)
            chk($sformatf("leftover_ch%0d", i), sbq[i].size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/onehot_demux.md
Name: onehot_demux

Overview:
- Registered one-hot demultiplexer: the inverse of the team's one-hot mux.
- Steers one valid/ready input stream to one of `outputs` independent valid/ready output channels, chosen by a one-hot select that travels with each beat.
- Each output channel has a one-entry holding register, so a stalled channel never blocks beats bound for other channels.
- Sits between a single producer and N consumers, e.g. a response fan-out.

Parameters:
- outputs, 4: number of output channels; must be >= 2.
- width, 8: data width in bits.
- cnt_width, 8: width of the saturating illegal-select counter.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_data  input  width  input beat payload.
- in_sel  input  outputs  one-hot destination. in_sel[outputs-1-i]=1 selects channel i, so the MSB selects channel 0, matching the mux convention.
- in_valid  input  1  input beat valid.
- in_ready  output  1  input beat accepted when in_valid && in_ready.
- out_data  output  width x outputs  unpacked array; out_data[i] is the payload for channel i.
- out_valid  output  outputs  out_valid[i] is valid for channel i.
- out_ready  input  outputs  out_ready[i] is ready for channel i.
- err_pulse  output  1  one-cycle pulse: an illegal select was consumed.
- err_count  output  cnt_width  saturating count of illegal beats.

Behaviour:
- Reset (rst_n=0, asynchronous, immediate, no clock needed):
  - out_valid=0, all out_data=0, err_pulse=0, err_count=0.
  - Any held beats are discarded.
  - Normal operation resumes on the first rising edge after rst_n rises.
- Select decode:
  - sel_ok = exactly one bit of in_sel is set.
  - d = the channel index i with in_sel[outputs-1-i]=1.
- in_ready (combinational from in_sel, out_valid, out_ready; independent of in_valid):
  - if !sel_ok: in_ready=1. Illegal beats are always consumed.
  - else: in_ready = !out_valid[d] || out_ready[d].
- Legal accept (in_valid && in_ready && sel_ok):
  - Next edge: out_data[d] <= in_data, out_valid[d] <= 1.
  - Latency: 1 cycle from acceptance to out_valid.
- Drain: out_valid[i] && out_ready[i] with no load to i in the same cycle gives out_valid[i] <= 0 on the next edge. out_data[i] keeps its last value.
- Simultaneous drain and load on the same channel: out_valid[i] stays 1 and out_data[i] takes the new beat. Sustained throughput is 1 beat/cycle per channel.
- Holding rule: while out_valid[i] && !out_ready[i], out_data[i] must not change.
- Channels are independent. A full, stalled channel i blocks only input beats addressed to i. Other channels keep draining.
- Illegal beat (in_valid && !sel_ok, i.e. zero bits or more than one bit set):
  - No out_valid or out_data changes.
  - Next edge: err_pulse=1 for exactly one cycle.
  - err_count increments, saturating at 2^cnt_width-1 (no wrap).
- No legal-select checking or counting happens when in_valid=0; in_sel is don't-care then.
- Producer contract: in_data and in_sel stay stable while in_valid && !in_ready. A violation is not detected; the bench flags it as a protocol error.

Test Plan:
1. Reset check: assert rst_n=0 mid-run with out_valid=4'b0101 -> out_valid=0, out_data[*]=0 and err_count=0 immediately (same time step, no clk edge); first beat after release is routed normally.
2. Basic routing: in_sel=4'b1000, in_data=8'hA5 and one cycle later in_sel=4'b0001, in_data=8'h3C, out_ready all 1 -> out_valid=4'b0001 with out_data[0]=8'hA5 one cycle after the first beat, then out_valid=4'b1000 with out_data[3]=8'h3C; in_ready=1 throughout.
3. Backpressure on channel 2: out_ready[2]=0, send 8'h11 and then 8'h22 with in_sel=4'b0010 -> 8'h11 held in out_data[2], in_ready=0 for the second beat. Meanwhile send 8'h77 to in_sel=4'b0100 -> out_data[1]=8'h77 delivered. Raise out_ready[2] -> 8'h22 loads on the same edge 8'h11 drains, and out_valid[2] stays 1.
4. Illegal selects: in_sel=4'b0110 and then 4'b0000, each with in_valid=1 -> in_ready=1, no out_valid change, err_pulse high one cycle per beat, err_count=2.
5. Saturation (cnt_width=8): 260 back-to-back illegal beats -> err_count=255, stays at 255, no wrap; err_pulse high every cycle.
6. Full-rate streaming: 64 beats round-robin over channels 0..3 with random out_ready -> each channel's output sequence equals its input sequence, with no loss, duplication or reordering.
